// File: rtl/enigma_pkg.sv
// -----------------------------------------------------------------------------
// enigma_pkg
//   Shared types and helpers for the rotor stepping controller.
//   ALPHA_SIZE : number of letters; positions and letters live in 0..ALPHA_SIZE-1
//   LETTER_W   : width of a letter/position value
//   letter_t   : one letter or rotor position
//   ctrl_state_t : controller FSM states (IDLE, STEP, ENC, OUT)
//   wrap_inc() : +1 modulo ALPHA_SIZE
//   clamp_letter() : out-of-alphabet values collapse to 0
// -----------------------------------------------------------------------------
package enigma_pkg;

  localparam int ALPHA_SIZE = 26;
  localparam int LETTER_W   = 5;

  typedef logic [LETTER_W-1:0] letter_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    ENC  = 2'd2,
    OUT  = 2'd3
  } ctrl_state_t;

  // Increment modulo the alphabet. Anything at or above the last letter wraps
  // to 0, so the result never lands in the unused codes 26..31.
  function automatic letter_t wrap_inc(letter_t x);
    if (x >= letter_t'(ALPHA_SIZE - 1)) begin
      return '0;
    end
    return x + letter_t'(1);
  endfunction

  function automatic letter_t clamp_letter(letter_t x);
    return (x >= letter_t'(ALPHA_SIZE)) ? '0 : x;
  endfunction

endpackage

// File: rtl/rotor_stepper.sv
// -----------------------------------------------------------------------------
// rotor_stepper
//   Combinational next-position logic for the three rotors, decided entirely
//   from the pre-step positions.
//   Optional feature macro: ENIGMA_DOUBLE_STEP_EN (historical double-step of
//   the middle rotor). Undefined gives a pure odometer.
// Ports
//   r1_i/r2_i/r3_i     : current fast/middle/slow positions
//   notch1_i/notch2_i  : notch positions of rotor1 and rotor2
//   r1_o/r2_o/r3_o     : positions after one keypress
// -----------------------------------------------------------------------------
module rotor_stepper
  import enigma_pkg::*;
(
  input  logic [LETTER_W-1:0] r1_i,
  input  logic [LETTER_W-1:0] r2_i,
  input  logic [LETTER_W-1:0] r3_i,
  input  logic [LETTER_W-1:0] notch1_i,
  input  logic [LETTER_W-1:0] notch2_i,
  output logic [LETTER_W-1:0] r1_o,
  output logic [LETTER_W-1:0] r2_o,
  output logic [LETTER_W-1:0] r3_o
);

  logic carry2;   // fast rotor sits on its notch
  logic mid_at;   // middle rotor sits on its notch
  logic adv2;
  logic adv3;

  assign carry2 = (r1_i == notch1_i);
  assign mid_at = (r2_i == notch2_i);

`ifdef ENIGMA_DOUBLE_STEP_EN
  // Middle rotor on its own notch drags itself and the slow rotor along,
  // even without a carry from the fast rotor. Each advances at most once.
  assign adv2 = carry2 | mid_at;
  assign adv3 = mid_at;
`else
  assign adv2 = carry2;
  assign adv3 = carry2 & mid_at;
`endif

  assign r1_o = wrap_inc(r1_i);
  assign r2_o = adv2 ? wrap_inc(r2_i) : r2_i;
  assign r3_o = adv3 ? wrap_inc(r3_i) : r3_i;

endmodule

// File: rtl/rotor_step_controller.sv
// -----------------------------------------------------------------------------
// rotor_step_controller
//   Sequencer between the char stream and the rotor substitution datapath.
//   Accepts one letter, steps the rotors, requests one encryption while the
//   positions are held, then offers the ciphertext downstream. Symbols
//   (in_char >= ALPHA) bypass stepping and encryption.
//   Optional feature macro: ENIGMA_DOUBLE_STEP_EN (see rotor_stepper).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. in_valid/in_ready upstream, out_valid/out_ready downstream,
//   enc_req/enc_ack to the datapath (enc_ack is ignored unless enc_req=1).
//   Valid outputs, once raised, stay high with stable data until accepted.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   cfg_load, cfg_pos, cfg_notch : load start positions + notches (IDLE only)
//   msg_restart         : rewind positions to last loaded cfg_pos (IDLE only)
//   in_valid/in_ready/in_char    : plaintext input
//   enc_req/enc_char/enc_ack/enc_result : datapath request/response
//   rotor1_pos/rotor2_pos/rotor3_pos : fast/middle/slow positions
//   out_valid/out_ready/out_char : ciphertext output
//   busy                : controller not in IDLE
//   dbg_state           : raw FSM state (IDLE=0, STEP=1, ENC=2, OUT=3)
// -----------------------------------------------------------------------------
module rotor_step_controller
  import enigma_pkg::*;
#(
  // ALPHA and W must agree with enigma_pkg; the stepper is built on the package.
  parameter int ALPHA      = ALPHA_SIZE,
  parameter int W          = LETTER_W,
  parameter int NOTCH1_DEF = 16,
  parameter int NOTCH2_DEF = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_load,
  input  logic [14:0]  cfg_pos,
  input  logic [9:0]   cfg_notch,
  input  logic         msg_restart,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_char,
  output logic         enc_req,
  output logic [W-1:0] enc_char,
  input  logic         enc_ack,
  input  logic [W-1:0] enc_result,
  output logic [W-1:0] rotor1_pos,
  output logic [W-1:0] rotor2_pos,
  output logic [W-1:0] rotor3_pos,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_char,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_STEP = STEP;
  localparam logic [1:0] S_ENC  = ENC;
  localparam logic [1:0] S_OUT  = OUT;

  localparam logic [W-1:0] ALPHA_L  = W'(ALPHA);
  localparam logic [W-1:0] NOTCH1_L = W'(NOTCH1_DEF);
  localparam logic [W-1:0] NOTCH2_L = W'(NOTCH2_DEF);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [14:0]  sav_q, sav_d;      // last loaded start positions, already clamped
  logic [W-1:0] n1_q, n1_d, n2_q, n2_d;
  logic [W-1:0] enc_char_q, enc_char_d;
  logic [W-1:0] out_char_q, out_char_d;

  logic [W-1:0] r1_step, r2_step, r3_step;

  rotor_stepper u_stepper (
    .r1_i     (r1_q),
    .r2_i     (r2_q),
    .r3_i     (r3_q),
    .notch1_i (n1_q),
    .notch2_i (n2_q),
    .r1_o     (r1_step),
    .r2_o     (r2_step),
    .r3_o     (r3_step)
  );

  always_comb begin
    state_d    = state_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    r3_d       = r3_q;
    sav_d      = sav_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    enc_char_d = enc_char_q;
    out_char_d = out_char_q;
    case (state_q)
      S_IDLE: begin
        // cfg_load beats msg_restart; either one blocks the char this cycle.
        if (cfg_load) begin
          r1_d  = clamp_letter(cfg_pos[14:10]);
          r2_d  = clamp_letter(cfg_pos[9:5]);
          r3_d  = clamp_letter(cfg_pos[4:0]);
          sav_d = {clamp_letter(cfg_pos[14:10]), clamp_letter(cfg_pos[9:5]),
                   clamp_letter(cfg_pos[4:0])};
          n1_d  = clamp_letter(cfg_notch[9:5]);
          n2_d  = clamp_letter(cfg_notch[4:0]);
        end else if (msg_restart) begin
          r1_d = sav_q[14:10];
          r2_d = sav_q[9:5];
          r3_d = sav_q[4:0];
        end else if (in_valid) begin
          enc_char_d = in_char;
          if (in_char >= ALPHA_L) begin
            out_char_d = in_char;
            state_d    = S_OUT;
          end else begin
            state_d = S_STEP;
          end
        end
      end
      S_STEP: begin
        r1_d    = r1_step;
        r2_d    = r2_step;
        r3_d    = r3_step;
        state_d = S_ENC;
      end
      S_ENC: begin
        if (enc_ack) begin
          out_char_d = enc_result;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r1_q       <= '0;
      r2_q       <= '0;
      r3_q       <= '0;
      sav_q      <= '0;
      n1_q       <= NOTCH1_L;
      n2_q       <= NOTCH2_L;
      enc_char_q <= '0;
      out_char_q <= '0;
    end else begin
      state_q    <= state_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      r3_q       <= r3_d;
      sav_q      <= sav_d;
      n1_q       <= n1_d;
      n2_q       <= n2_d;
      enc_char_q <= enc_char_d;
      out_char_q <= out_char_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE) && !cfg_load && !msg_restart;
  assign enc_req    = (state_q == S_ENC);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign enc_char   = enc_char_q;
  assign out_char   = out_char_q;
  assign rotor1_pos = r1_q;
  assign rotor2_pos = r2_q;
  assign rotor3_pos = r3_q;
  assign dbg_state  = state_q;

endmodule
